// File: rtl/cross_product.sv
// Pipelined 3-D cross product over the first three elements of homogeneous vectors.
// Stage 1 registers six signed products; stage 2 registers wrapped differences and overflow flags.
module cross_product #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  input  logic [WIDTH-1:0] b1,
  input  logic [WIDTH-1:0] b2,
  input  logic [WIDTH-1:0] b3,
  input  logic [WIDTH-1:0] b4,
  output logic             out_valid,
  output logic [WIDTH-1:0] c1,
  output logic [WIDTH-1:0] c2,
  output logic [WIDTH-1:0] c3,
  output logic [WIDTH-1:0] c4,
  output logic [2:0]       ovf
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] a [3];
  logic [WIDTH-1:0] b [3];
  logic [PW-1:0]    pos_d [3];
  logic [PW-1:0]    neg_d [3];
  logic [PW-1:0]    pos_q [3];
  logic [PW-1:0]    neg_q [3];
  logic             v1_q;
  logic [PW:0]      diff [3];
  logic [WIDTH-1:0] c_d [3];
  logic [WIDTH-1:0] c_q [3];
  logic [2:0]       ovf_d;
  logic [2:0]       ovf_q;
  logic             out_valid_q;

  // The fourth (homogeneous) element carries no weight in a direction result.
  logic unused_w;
  assign unused_w = ^{a4, b4};

  assign a[0] = a1;
  assign a[1] = a2;
  assign a[2] = a3;
  assign b[0] = b1;
  assign b[1] = b2;
  assign b[2] = b3;

  // Sign-extended operands make the modular product equal the exact signed product.
  function automatic logic [PW-1:0] smul(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [PW-1:0] xe;
    logic [PW-1:0] ye;
    xe = {{WIDTH{x[WIDTH-1]}}, x};
    ye = {{WIDTH{y[WIDTH-1]}}, y};
    return xe * ye;
  endfunction

  // ck = a[k+1]*b[k+2] - a[k+2]*b[k+1], indices mod 3.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      pos_d[k] = smul(a[(k + 1) % 3], b[(k + 2) % 3]);
      neg_d[k] = smul(a[(k + 2) % 3], b[(k + 1) % 3]);
    end
  end

  always_comb begin
    ovf_d = '0;
    for (int k = 0; k < 3; k++) begin
      diff[k]  = {pos_q[k][PW-1], pos_q[k]} - {neg_q[k][PW-1], neg_q[k]};
      c_d[k]   = diff[k][WIDTH-1:0];
      // Fits in WIDTH signed bits only if all bits from the WIDTH sign bit upward agree.
      ovf_d[k] = !((&diff[k][PW:WIDTH-1]) || !(|diff[k][PW:WIDTH-1]));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        pos_q[k] <= '0;
        neg_q[k] <= '0;
      end
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < 3; k++) begin
          pos_q[k] <= pos_d[k];
          neg_q[k] <= neg_d[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ovf_q       <= '0;
      for (int k = 0; k < 3; k++) begin
        c_q[k] <= '0;
      end
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        ovf_q <= ovf_d;
        for (int k = 0; k < 3; k++) begin
          c_q[k] <= c_d[k];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign c1        = c_q[0];
  assign c2        = c_q[1];
  assign c3        = c_q[2];
  assign c4        = '0;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cross_product.sv
// Self-checking bench for cross_product: directed cases plus random streaming against an
// integer-arithmetic model with a due-cycle scoreboard.
module tb_cross_product;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a1 = '0, a2 = '0, a3 = '0, a4 = '0;
  logic [W-1:0] b1 = '0, b2 = '0, b3 = '0, b4 = '0;
  logic         out_valid;
  logic [W-1:0] c1, c2, c3, c4;
  logic [2:0]   ovf;

  typedef struct {
    int           due;
    logic [W-1:0] e1;
    logic [W-1:0] e2;
    logic [W-1:0] e3;
    logic [2:0]   eovf;
  } exp_t;

  exp_t queue_q[$];
  exp_t last;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   va [3];
  int   vb [3];

  cross_product #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .a4       (a4),
    .b1       (b1),
    .b2       (b2),
    .b3       (b3),
    .b4       (b4),
    .out_valid(out_valid),
    .c1       (c1),
    .c2       (c2),
    .c3       (c3),
    .c4       (c4),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, want);
    end
  endtask

  // Exact integer cross product, then wrap and range test.
  function automatic exp_t model(input int due);
    exp_t e;
    int   ex [3];
    ex[0] = va[1] * vb[2] - va[2] * vb[1];
    ex[1] = va[2] * vb[0] - va[0] * vb[2];
    ex[2] = va[0] * vb[1] - va[1] * vb[0];
    e.due = due;
    e.e1  = ex[0][W-1:0];
    e.e2  = ex[1][W-1:0];
    e.e3  = ex[2][W-1:0];
    for (int k = 0; k < 3; k++) begin
      e.eovf[k] = (ex[k] < -(1 << (W - 1))) || (ex[k] > (1 << (W - 1)) - 1);
    end
    return e;
  endfunction

  task automatic set_vec(input int x1, input int x2, input int x3, input int x4,
                         input int y1, input int y2, input int y3, input int y4);
    va[0] = x1; va[1] = x2; va[2] = x3;
    vb[0] = y1; vb[1] = y2; vb[2] = y3;
    a1 = x1[W-1:0]; a2 = x2[W-1:0]; a3 = x3[W-1:0]; a4 = x4[W-1:0];
    b1 = y1[W-1:0]; b2 = y2[W-1:0]; b3 = y3[W-1:0]; b4 = y4[W-1:0];
  endtask

  task automatic check_outputs();
    logic exp_v;
    exp_v = (queue_q.size() > 0) && (queue_q[0].due == cyc);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
    if (exp_v) last = queue_q.pop_front();
    check("c1", {24'd0, c1}, {24'd0, last.e1});
    check("c2", {24'd0, c2}, {24'd0, last.e2});
    check("c3", {24'd0, c3}, {24'd0, last.e3});
    check("c4", {24'd0, c4}, 32'd0);
    check("ovf", {29'd0, ovf}, {29'd0, last.eovf});
  endtask

  // Called just after a falling edge: drive, let one rising edge pass, check.
  task automatic step(input logic v);
    in_valid = v;
    if (v) queue_q.push_back(model(cyc + 2));
    @(negedge clk);
    check_outputs();
  endtask

  function automatic int rand_elem();
    int r;
    r = int'($urandom_range(0, 255));
    if ($urandom_range(0, 7) == 0) r = ($urandom_range(0, 1) == 1) ? 127 : 128;
    return (r > 127) ? r - 256 : r;
  endfunction

  task automatic set_random();
    set_vec(rand_elem(), rand_elem(), rand_elem(), rand_elem(),
            rand_elem(), rand_elem(), rand_elem(), rand_elem());
  endtask

  initial begin
    last = '{due: 0, e1: '0, e2: '0, e3: '0, eovf: '0};
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_c4", {24'd0, c4}, 32'd0);
    check("rst_ovf", {29'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Basic, unit axes, overflow wrap cases.
    set_vec(0, 2, 4, 6, 1, 3, 5, 7);     step(1'b1);
    set_vec(0, 0, 0, 0, 0, 0, 0, 0);     step(1'b0); step(1'b0); step(1'b0);
    set_vec(1, 0, 0, 9, 0, 1, 0, 5);     step(1'b1); step(1'b0); step(1'b0);
    set_vec(0, 127, 0, 0, 0, 0, 127, 0); step(1'b1); step(1'b0); step(1'b0);
    set_vec(0, -128, 0, 0, 0, 0, -128, 0); step(1'b1); step(1'b0); step(1'b0);

    // Streaming four distinct ops.
    set_vec(3, -5, 7, 1, -2, 4, 6, 2);        step(1'b1);
    set_vec(-128, 127, -128, 0, 127, -128, 127, 0); step(1'b1);
    set_vec(10, 20, 30, 3, -40, 50, -60, 4);  step(1'b1);
    set_vec(1, 1, 1, 1, 2, 2, 2, 2);          step(1'b1);
    set_vec(99, 99, 99, 99, 99, 99, 99, 99);  step(1'b0); step(1'b0); step(1'b0);

    // Bubble pattern 1,0,1 with garbage on the inputs during the gap.
    set_vec(5, 6, 7, 0, 8, 9, 10, 0);         step(1'b1);
    set_vec(-77, 55, 33, 11, 22, -99, 44, 66); step(1'b0);
    set_vec(-3, 12, -9, 0, 4, -6, 15, 0);     step(1'b1);
    step(1'b0); step(1'b0); step(1'b0);

    // Reset while an op sits in stage 1: it must never emerge.
    set_vec(11, -22, 33, 0, -44, 55, -66, 0);
    in_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_c1", {24'd0, c1}, 32'd0);
    check("mid_rst_c2", {24'd0, c2}, 32'd0);
    check("mid_rst_c3", {24'd0, c3}, 32'd0);
    check("mid_rst_ovf", {29'd0, ovf}, 32'd0);
    in_valid = 1'b0;
    queue_q.delete();
    last = '{due: 0, e1: '0, e2: '0, e3: '0, eovf: '0};
    @(negedge clk);
    rst = 1'b0;
    step(1'b0); step(1'b0); step(1'b0);
    set_vec(2, 3, 4, 0, 5, 6, 7, 0);          step(1'b1);
    step(1'b0); step(1'b0);

    // Random stream with roughly 70% valid.
    for (int i = 0; i < 300; i++) begin
      set_random();
      step($urandom_range(0, 9) < 7);
    end
    for (int i = 0; i < 4; i++) begin
      set_random();
      step(1'b0);
    end
    check("queue_drained", queue_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
